// File: rtl/count_sched.sv
// Two-requester shared counter with round-robin arbitration and a run/finish handshake.
// Define COUNT_SCHED_FIXED_PRIO_EN to make requester 0 win every tie (fixed priority).
module count_sched #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic [1:0]       REQ,
  input  logic [WIDTH-1:0] LEN0,
  input  logic [WIDTH-1:0] LEN1,
  output logic [1:0]       GNT,
  output logic [WIDTH-1:0] O,
  output logic             TC,
  output logic [1:0]       DONE,
  output logic             BUSY
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  logic [1:0]       state;
  logic             owner;
  logic [WIDTH-1:0] len_q;
  logic [WIDTH-1:0] o_q;
  logic             winner;

`ifdef COUNT_SCHED_FIXED_PRIO_EN
  // Requester 0 wins whenever its bit is set, so LAST is not needed at all.
  assign winner = ~REQ[0];
`else
  logic last;

  // NOTE: always_comb assigns a default first so no path can infer a latch.
  always_comb begin
    winner = ~REQ[0];
    if (REQ == 2'b11) winner = ~last;
  end
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of its peers.
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state <= S_IDLE;
      owner <= 1'b0;
      len_q <= '0;
      o_q   <= '0;
`ifndef COUNT_SCHED_FIXED_PRIO_EN
      last  <= 1'b1;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (|REQ) begin
            owner <= winner;
            len_q <= winner ? LEN1 : LEN0;
            o_q   <= '0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          // Owner withdrawing its request takes priority over completion.
          if (!REQ[owner]) begin
            o_q   <= '0;
            state <= S_IDLE;
          end else if (o_q == len_q) begin
            state <= S_FIN;
          end else begin
            o_q <= o_q + WIDTH'(1);
          end
        end
        S_FIN: begin
`ifndef COUNT_SCHED_FIXED_PRIO_EN
          last  <= owner;
`endif
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign O    = o_q;
  assign BUSY = (state != S_IDLE);
  assign TC   = (state == S_RUN) && (o_q == len_q);
  assign GNT  = (state == S_RUN) ? (owner ? 2'b10 : 2'b01) : 2'b00;
  assign DONE = (state == S_FIN) ? (owner ? 2'b10 : 2'b01) : 2'b00;

endmodule

// File: tb/tb_count_sched.sv
// Self-checking bench for count_sched: directed scenarios plus randomized traffic
// compared cycle by cycle against a phase-level reference model.
module tb_count_sched;

  localparam int W = 4;
  localparam int VW = W + 6;

  logic          CLK = 1'b0;
  logic          RESETN = 1'b0;
  logic [1:0]    REQ = 2'b00;
  logic [W-1:0]  LEN0 = '0;
  logic [W-1:0]  LEN1 = '0;
  logic [1:0]    GNT;
  logic [W-1:0]  O;
  logic          TC;
  logic [1:0]    DONE;
  logic          BUSY;

  int tests_run = 0;
  int tests_failed = 0;

  count_sched #(.WIDTH(W)) dut (
    .CLK(CLK), .RESETN(RESETN), .REQ(REQ), .LEN0(LEN0), .LEN1(LEN1),
    .GNT(GNT), .O(O), .TC(TC), .DONE(DONE), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  logic [VW-1:0] obs;
  assign obs = {GNT, O, TC, DONE, BUSY};

  function automatic logic [VW-1:0] pack(input int gnt, input int o, input int tc,
                                         input int done, input int busy);
    logic [1:0]   g = gnt[1:0];
    logic [W-1:0] ov = o[W-1:0];
    logic [1:0]   d = done[1:0];
    return {g, ov, tc[0], d, busy[0]};
  endfunction

  // Reference model: phase 0 = waiting, 1 = counting, 2 = finishing.
  int m_phase = 0;
  int m_owner = 0;
  int m_cnt = 0;
  int m_len = 0;
  int m_last = 1;

  function automatic int pick(input logic [1:0] req, input int last);
`ifdef COUNT_SCHED_FIXED_PRIO_EN
    return req[0] ? 0 : 1;
`else
    if (req == 2'b11) return (last == 1) ? 0 : 1;
    return req[0] ? 0 : 1;
`endif
  endfunction

  always @(posedge CLK) begin
    if (!RESETN) begin
      m_phase <= 0; m_owner <= 0; m_cnt <= 0; m_len <= 0; m_last <= 1;
    end else if (m_phase == 0) begin
      if (REQ != 2'b00) begin
        m_owner <= pick(REQ, m_last);
        m_len   <= (pick(REQ, m_last) == 1) ? int'(LEN1) : int'(LEN0);
        m_cnt   <= 0;
        m_phase <= 1;
      end
    end else if (m_phase == 1) begin
      if (!REQ[m_owner]) begin
        m_phase <= 0; m_cnt <= 0;
      end else if (m_cnt == m_len) begin
        m_phase <= 2;
      end else begin
        m_cnt <= (m_cnt + 1) % (1 << W);
      end
    end else begin
      m_last  <= m_owner;
      m_phase <= 0;
    end
  end

  function automatic logic [VW-1:0] model_expect();
    int bit_own = 1 << m_owner;
    return pack((m_phase == 1) ? bit_own : 0, m_cnt,
                (m_phase == 1 && m_cnt == m_len) ? 1 : 0,
                (m_phase == 2) ? bit_own : 0, (m_phase != 0) ? 1 : 0);
  endfunction

  task automatic test_reset();
    logic [VW-1:0] exp;
    RESETN = 1'b0; REQ = 2'b11; LEN0 = 4'd5; LEN1 = 4'd6;
    repeat (2) @(negedge CLK);
    exp = pack(0, 0, 0, 0, 0);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL reset obs=%h exp=%h", obs, exp);
    end
    REQ = 2'b00; RESETN = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_single();
    logic [VW-1:0] exp;
    REQ = 2'b01; LEN0 = 4'd3;
    for (int k = 0; k <= 3; k++) begin
      @(negedge CLK);
      LEN0 = 4'd9;  // must not affect the latched length
      exp = pack(1, k, (k == 3) ? 1 : 0, 0, 1);
      tests_run++;
      if (obs !== exp) begin
        tests_failed++;
        $display("FAIL single run k=%0d obs=%h exp=%h", k, obs, exp);
      end
    end
    @(negedge CLK);
    exp = pack(0, 3, 0, 1, 1);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL single fin obs=%h exp=%h", obs, exp);
    end
    REQ = 2'b00;
    @(negedge CLK);
    exp = pack(0, 3, 0, 0, 0);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL single idle obs=%h exp=%h", obs, exp);
    end
  endtask

  task automatic test_tie();
    logic [VW-1:0] exp;
    int own;
    int len;
    RESETN = 1'b0;
    @(negedge CLK);
    RESETN = 1'b1; REQ = 2'b11; LEN0 = 4'd2; LEN1 = 4'd1;
    for (int r = 0; r < 3; r++) begin
`ifdef COUNT_SCHED_FIXED_PRIO_EN
      own = 0;
`else
      own = r % 2;
`endif
      len = (own == 1) ? 1 : 2;
      for (int k = 0; k <= len; k++) begin
        @(negedge CLK);
        exp = pack(1 << own, k, (k == len) ? 1 : 0, 0, 1);
        tests_run++;
        if (obs !== exp) begin
          tests_failed++;
          $display("FAIL tie run r=%0d k=%0d obs=%h exp=%h", r, k, obs, exp);
        end
      end
      @(negedge CLK);
      exp = pack(0, len, 0, 1 << own, 1);
      tests_run++;
      if (obs !== exp) begin
        tests_failed++;
        $display("FAIL tie fin r=%0d obs=%h exp=%h", r, obs, exp);
      end
      if (r == 2) REQ = 2'b00;
      @(negedge CLK);
      exp = pack(0, len, 0, 0, 0);
      tests_run++;
      if (obs !== exp) begin
        tests_failed++;
        $display("FAIL tie idle r=%0d obs=%h exp=%h", r, obs, exp);
      end
    end
  endtask

  task automatic test_zero_len();
    logic [VW-1:0] exp;
    REQ = 2'b10; LEN1 = 4'd0; LEN0 = 4'd7;
    @(negedge CLK);
    exp = pack(2, 0, 1, 0, 1);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL zero run obs=%h exp=%h", obs, exp);
    end
    @(negedge CLK);
    exp = pack(0, 0, 0, 2, 1);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL zero fin obs=%h exp=%h", obs, exp);
    end
    REQ = 2'b00;
    @(negedge CLK);
  endtask

  task automatic test_abort();
    logic [VW-1:0] exp;
    REQ = 2'b01; LEN0 = 4'd15;
    for (int k = 0; k <= 5; k++) begin
      @(negedge CLK);
      REQ[1] = k[0];  // non-owner toggling has no effect
      exp = pack(1, k, 0, 0, 1);
      tests_run++;
      if (obs !== exp) begin
        tests_failed++;
        $display("FAIL abort run k=%0d obs=%h exp=%h", k, obs, exp);
      end
    end
    REQ = 2'b00;
    for (int k = 0; k < 2; k++) begin
      @(negedge CLK);
      exp = pack(0, 0, 0, 0, 0);
      tests_run++;
      if (obs !== exp) begin
        tests_failed++;
        $display("FAIL abort idle c=%0d obs=%h exp=%h", k, obs, exp);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    logic [VW-1:0] exp;
    REQ = 2'b01; LEN0 = 4'd15;
    for (int k = 0; k <= 7; k++) begin
      @(negedge CLK);
      exp = pack(1, k, 0, 0, 1);
      tests_run++;
      if (obs !== exp) begin
        tests_failed++;
        $display("FAIL rstmid run k=%0d obs=%h exp=%h", k, obs, exp);
      end
    end
    RESETN = 1'b0;
    @(negedge CLK);
    exp = pack(0, 0, 0, 0, 0);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL rstmid reset obs=%h exp=%h", obs, exp);
    end
    RESETN = 1'b1; REQ = 2'b11; LEN0 = 4'd4; LEN1 = 4'd9;
    @(negedge CLK);
    exp = pack(1, 0, 0, 0, 1);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL rstmid regrant obs=%h exp=%h", obs, exp);
    end
    REQ = 2'b00;
    @(negedge CLK);
  endtask

  task automatic test_random();
    logic [VW-1:0] exp;
    int errs = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge CLK);
      exp = model_expect();
      tests_run++;
      if (obs !== exp || (GNT == 2'b11) || (DONE == 2'b11)) begin
        tests_failed++;
        if (errs < 10)
          $display("FAIL random c=%0d obs=%h exp=%h", c, obs, exp);
        errs++;
      end
      if ($urandom_range(7) == 0) REQ = 2'($urandom_range(3));
      LEN0 = W'($urandom_range(15));
      LEN1 = W'($urandom_range(15));
      RESETN = ($urandom_range(149) != 0);
    end
    RESETN = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_zero_len();
    test_abort();
    test_reset_mid_run();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
